// File: rtl/xclk_fwd_pkg.sv
// Shared types and defaults for the forwarded-clock controller.
package xclk_fwd_pkg;

  localparam int unsigned DivWDefault   = 4;
  localparam int unsigned DefDivDefault = 2;
  // Wide enough for START_DLY values up to 255.
  localparam int unsigned StartCntW     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/xclk_phase_gen.sv
// Half-cycle slot counter for the forwarded clock: tracks slot index h, flags the period wrap
// and decodes the two DDR data slots.
module xclk_phase_gen
  import xclk_fwd_pkg::*;
#(
  parameter int unsigned DIV_W = DivWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic [DIV_W-1:0] div,
  output logic             wrap,
  output logic             d0,
  output logic             d1
);

  // Two extra bits hold h+2 up to 2P without overflow.
  localparam int unsigned HW = DIV_W + 2;

  logic [HW-1:0] h_q, h_d;
  logic [HW-1:0] h_plus2;
  logic [HW-1:0] p_ext;
  logic [HW-1:0] two_p;

  assign p_ext   = HW'(div);
  assign two_p   = HW'({div, 1'b0});
  assign h_plus2 = h_q + HW'(2);
  assign wrap    = advance & (h_plus2 >= two_p);

  // h parks at 0 outside RUN/DRAIN so the first RUN cycle starts a clean period.
  always_comb begin
    h_d = '0;
    if (advance && !wrap) begin
      h_d = h_plus2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
    end else begin
      h_q <= h_d;
    end
  end

  assign d0 = advance & (h_q < p_ext);
  assign d1 = advance & ((h_q + HW'(1)) < p_ext);

endmodule

// File: rtl/xclk_fwd_ctrl.sv
// Forwarded-clock controller driving a DDR output register with a glitch-free divided clock.
// Define XCLK_FWD_PERCNT_EN to build the completed-period counter on per_cnt.
module xclk_fwd_ctrl
  import xclk_fwd_pkg::*;
#(
  parameter int unsigned DIV_W     = DivWDefault,
  parameter int unsigned DEF_DIV   = DefDivDefault,
  parameter int unsigned START_DLY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             oddr_d0,
  output logic             oddr_d1,
  output logic             oddr_ce,
  output logic             oddr_r,
  output logic             oddr_s,
  output logic             running,
  output logic [31:0]      per_cnt
);

  localparam logic [StartCntW-1:0] StartLast = StartCntW'(START_DLY - 1);
  localparam logic [DIV_W-1:0]     DefDiv    = (DEF_DIV == 0) ? DIV_W'(1) : DIV_W'(DEF_DIV);

  state_e                 state_q, state_d;
  logic [StartCntW-1:0]   cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [DIV_W-1:0]       pend_div_q, pend_div_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [DIV_W-1:0]       cfg_div_norm;
  logic                   advance;
  logic                   wrap;
  logic                   accept;
  logic                   apply;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN ignores en so a re-request always restarts through START.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StStart;
      StStart: begin
        if (!en) begin
          state_d = StIdle;
        end else if (cnt_q == StartLast) begin
          state_d = StRun;
        end
      end
      StRun:   if (!en) state_d = StDrain;
      StDrain: if (wrap) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    oddr_r  = 1'b0;
    running = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle:  oddr_r = 1'b1;
      StStart: oddr_r = 1'b0;
      StRun, StDrain: begin
        running = 1'b1;
        advance = 1'b1;
      end
      default: oddr_r = 1'b1;
    endcase
  end

  assign oddr_ce = 1'b1;
  assign oddr_s  = 1'b0;

  assign cfg_div_norm = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign cfg_ready    = ~pend_q;
  assign accept       = cfg_valid & ~pend_q;
  // While the clock toggles, a new divider only lands on a period boundary.
  assign apply        = pend_q & ((state_q == StIdle) | (state_q == StStart) | wrap);

  always_comb begin
    cnt_d      = (state_q == StStart) ? cnt_q + StartCntW'(1) : '0;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    div_d      = div_q;
    if (apply) begin
      pend_d = 1'b0;
      div_d  = pend_div_q;
    end
    if (accept) begin
      pend_d     = 1'b1;
      pend_div_d = cfg_div_norm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_div_q <= DefDiv;
      div_q      <= DefDiv;
    end else begin
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      div_q      <= div_d;
    end
  end

  xclk_phase_gen #(
    .DIV_W(DIV_W)
  ) u_phase_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(advance),
    .div    (div_q),
    .wrap   (wrap),
    .d0     (oddr_d0),
    .d1     (oddr_d1)
  );

`ifdef XCLK_FWD_PERCNT_EN
  logic [31:0] per_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
    end else if (wrap) begin
      per_cnt_q <= per_cnt_q + 32'd1;
    end
  end

  assign per_cnt = per_cnt_q;
`else
  assign per_cnt = '0;
`endif

endmodule
